lift_motion_sequencer: RTL

LIFT_MOTION_SEQUENCER -- requirements
Module: lift_motion_sequencer

---
 rtl/lift_pkg.sv | 31 +++
 rtl/lift_motion_sequencer_if.sv | 38 +++
 rtl/lift_cycle_timer.sv | 35 +++
 rtl/lift_motion_sequencer.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/lift_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lift_pkg
//  Description : Shared state encoding, default parameter values and helper
//                functions for the lift control blocks.
//  Revision    : 1.0  initial release
// ============================================================================
package lift_pkg;

    // Default configuration shared with the other lift blocks
    localparam int DEF_N_FLOORS          = 12;
    localparam int DEF_FLR_TRAVEL_CYCLES = 8;
    localparam int DEF_DOOR_MOVE_CYCLES  = 4;
    localparam int DEF_DOOR_OPEN_CYCLES  = 16;

    // Motion sequencer state encoding (visible on o_state)
    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        MOVING       = 3'd1,
        DOOR_OPENING = 3'd2,
        DOOR_OPEN    = 3'd3,
        DOOR_CLOSING = 3'd4
    } lift_state_t;

    // A duration of zero cycles is meaningless; treat it as one cycle
    function automatic int clamp1(input int v);
        return (v < 1) ? 1 : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lift_motion_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : lift_motion_sequencer_if
//  Description : Request inputs and motion/door outputs of the lift motion
//                sequencer. The master side is the request-evaluation logic,
//                the slave side is the sequencer itself.
//  Revision    : 1.0  initial release
// ============================================================================
interface lift_motion_sequencer_if
    import lift_pkg::*;
#(
    parameter int N_FLOORS = DEF_N_FLOORS
);
    logic                i_motion;
    logic                i_direction;
    logic                i_has_rqst_at_stopped_flr;
    logic                i_door_hold;
    logic [N_FLOORS-1:0] o_flr_pos;
    logic                o_door_open;
    logic                o_motor_up;
    logic                o_motor_dn;
    logic                o_door_closed_pulse;
    logic [2:0]          o_state;

    modport master (
        output i_motion, i_direction, i_has_rqst_at_stopped_flr, i_door_hold,
        input  o_flr_pos, o_door_open, o_motor_up, o_motor_dn,
               o_door_closed_pulse, o_state
    );

    modport slave (
        input  i_motion, i_direction, i_has_rqst_at_stopped_flr, i_door_hold,
        output o_flr_pos, o_door_open, o_motor_up, o_motor_dn,
               o_door_closed_pulse, o_state
    );

endinterface
`default_nettype wire

// File: rtl/lift_cycle_timer.sv
`default_nettype none
// ============================================================================
//  Module      : lift_cycle_timer
//  Description : Loadable down-counter. A loaded value of N makes o_done
//                assert in the N-th cycle after the load, so N is directly
//                the duration of the state that owns the timer.
//  Revision    : 1.0  initial release
// ============================================================================
module lift_cycle_timer #(
    parameter int WIDTH = 5
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             i_load,
    input  wire logic [WIDTH-1:0] i_load_val,
    output logic                  o_done
);

    logic [WIDTH-1:0] r_count;

    // Load has priority; otherwise count down and park at zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_done = (r_count == WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/lift_motion_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : lift_motion_sequencer
//  Description : Sequences hoist travel between adjacent floors and the door
//                open/dwell/close cycle. One shared timer paces every state.
//                Optional macro DOOR_REOPEN_EN: door-hold during closing
//                reopens the door.
//  Revision    : 1.0  initial release
// ============================================================================
module lift_motion_sequencer
    import lift_pkg::*;
#(
    parameter int N_FLOORS          = DEF_N_FLOORS,
    parameter int FLR_TRAVEL_CYCLES = DEF_FLR_TRAVEL_CYCLES,
    parameter int DOOR_MOVE_CYCLES  = DEF_DOOR_MOVE_CYCLES,
    parameter int DOOR_OPEN_CYCLES  = DEF_DOOR_OPEN_CYCLES
) (
    input  wire logic               clk,
    input  wire logic               reset,
    lift_motion_sequencer_if.slave  bus
);

    localparam int c_travel = clamp1(FLR_TRAVEL_CYCLES);
    localparam int c_move   = clamp1(DOOR_MOVE_CYCLES);
    localparam int c_open   = clamp1(DOOR_OPEN_CYCLES);
    localparam int c_tmax_a = (c_travel > c_move) ? c_travel : c_move;
    localparam int c_tmax   = (c_tmax_a > c_open) ? c_tmax_a : c_open;
    localparam int c_tw     = $clog2(c_tmax + 1);

    localparam logic [c_tw-1:0]     c_travel_v = c_tw'(c_travel);
    localparam logic [c_tw-1:0]     c_move_v   = c_tw'(c_move);
    localparam logic [c_tw-1:0]     c_open_v   = c_tw'(c_open);
    localparam logic [N_FLOORS-1:0] c_floor0   = {{(N_FLOORS-1){1'b0}}, 1'b1};

    lift_state_t         r_state;
    lift_state_t         w_next_state;
    logic                r_dir;
    logic [N_FLOORS-1:0] r_flr_pos;
    logic [N_FLOORS-1:0] r_saved_pos;
    logic                r_closed_pulse;
    logic                w_load;
    logic [c_tw-1:0]     w_load_val;
    logic                w_start_move;
    logic                w_arrive;
    logic                w_move_legal;
    logic                w_timer_done;

    lift_cycle_timer #(
        .WIDTH (c_tw)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_done     (w_timer_done)
    );

    // Moving past the top or bottom floor is refused; the car stays in IDLE
    assign w_move_legal = bus.i_direction ? ~r_flr_pos[N_FLOORS-1] : ~r_flr_pos[0];

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and timer loading
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_load_val   = '0;
        w_start_move = 1'b0;
        w_arrive     = 1'b0;
        case (r_state)
            IDLE: begin
                // A waiting passenger at this floor wins over a move request
                if (bus.i_has_rqst_at_stopped_flr) begin
                    w_next_state = DOOR_OPENING;
                    w_load       = 1'b1;
                    w_load_val   = c_move_v;
                end else if (bus.i_motion && w_move_legal) begin
                    w_next_state = MOVING;
                    w_load       = 1'b1;
                    w_load_val   = c_travel_v;
                    w_start_move = 1'b1;
                end
            end
            MOVING: begin
                if (w_timer_done) begin
                    w_next_state = IDLE;
                    w_arrive     = 1'b1;
                end
            end
            DOOR_OPENING: begin
                if (w_timer_done) begin
                    w_next_state = DOOR_OPEN;
                    w_load       = 1'b1;
                    w_load_val   = c_open_v;
                end
            end
            DOOR_OPEN: begin
                // Holding the button restarts the full dwell every cycle
                if (bus.i_door_hold) begin
                    w_load     = 1'b1;
                    w_load_val = c_open_v;
                end else if (w_timer_done) begin
                    w_next_state = DOOR_CLOSING;
                    w_load       = 1'b1;
                    w_load_val   = c_move_v;
                end
            end
            DOOR_CLOSING: begin
`ifdef DOOR_REOPEN_EN
                if (bus.i_door_hold) begin
                    w_next_state = DOOR_OPENING;
                    w_load       = 1'b1;
                    w_load_val   = c_move_v;
                end else if (w_timer_done) begin
                    w_next_state = IDLE;
                end
`else
                if (w_timer_done) begin
                    w_next_state = IDLE;
                end
`endif
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Position, latched direction and door-closed pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_flr_pos      <= c_floor0;
            r_saved_pos    <= c_floor0;
            r_dir          <= 1'b0;
            r_closed_pulse <= 1'b0;
        end else begin
            r_closed_pulse <= (r_state == DOOR_CLOSING) && (w_next_state == IDLE);
            if (w_start_move) begin
                r_dir       <= bus.i_direction;
                r_saved_pos <= r_flr_pos;
                r_flr_pos   <= '0;
            end else if (w_arrive) begin
                r_flr_pos <= r_dir ? (r_saved_pos << 1) : (r_saved_pos >> 1);
            end
        end
    end

    assign bus.o_flr_pos           = r_flr_pos;
    assign bus.o_state             = r_state;
    assign bus.o_door_open         = (r_state == DOOR_OPENING) || (r_state == DOOR_OPEN);
    assign bus.o_motor_up          = (r_state == MOVING) &&  r_dir;
    assign bus.o_motor_dn          = (r_state == MOVING) && !r_dir;
    assign bus.o_door_closed_pulse = r_closed_pulse;

endmodule
`default_nettype wire
